// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin scheduler that shares one UART transmitter between NUM_REQ
// sensor-data producers. The granted requester's message is latched and framed
// as a header byte (8'hA0 | id) followed by BYTES_PER_MSG payload bytes, MSB
// byte first. Bytes are handed to the transmitter one at a time through its
// DV / Done / Active handshake. Serial timing is left entirely to uart_tx.
//
// Optional feature: define UART_TX_ARB_CHECKSUM_EN to append one trailer byte
// equal to the XOR of the header and all payload bytes.
//
// Ports:
//   i_Clock      system clock, shared with the transmitter
//   i_Reset      asynchronous active-high reset
//   i_Req        level request per requester, held with stable data until acked
//   i_Data       requester r at [r*8*BYTES_PER_MSG +: 8*BYTES_PER_MSG]
//   o_Ack        one-cycle one-hot pulse: that requester's data was latched
//   o_Tx_DV      one-cycle byte-valid pulse to the transmitter
//   o_Tx_Byte    byte to send, valid while o_Tx_DV is high
//   i_Tx_Active  transmitter busy flag
//   i_Tx_Done    transmitter done flag (high 2 cycles at the end of a byte)
//   o_Busy       high from latch until the last byte's done flag falls
//   o_Grant_Id   index of the current or last granted requester
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int BYTES_PER_MSG = 4
) (
  input  logic                               i_Clock,
  input  logic                               i_Reset,
  input  logic [NUM_REQ-1:0]                 i_Req,
  input  logic [NUM_REQ*8*BYTES_PER_MSG-1:0] i_Data,
  output logic [NUM_REQ-1:0]                 o_Ack,
  output logic                               o_Tx_DV,
  output logic [7:0]                         o_Tx_Byte,
  input  logic                               i_Tx_Active,
  input  logic                               i_Tx_Done,
  output logic                               o_Busy,
  output logic [3:0]                         o_Grant_Id
);

  localparam int MSG_W = 8 * BYTES_PER_MSG;
  localparam int IDX_W = $clog2(BYTES_PER_MSG + 2);
  localparam int RID_W = $clog2(NUM_REQ);
`ifdef UART_TX_ARB_CHECKSUM_EN
  localparam int LAST_IDX = BYTES_PER_MSG + 1;
`else
  localparam int LAST_IDX = BYTES_PER_MSG;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_ISSUE,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] ack_q;
  logic               dv_q;
  logic [7:0]         byte_q;
  logic               busy_q;
  logic [3:0]         grant_q;   // doubles as the round-robin pointer
  logic [IDX_W-1:0]   idx_q;
  logic [7:0]         cks_q;
  logic [MSG_W-1:0]   word_q;

  logic               start_d;
  logic [3:0]         pick_d;
  logic [IDX_W-1:0]   idx_d;
  logic [7:0]         byte_d;

  // First requesting index after ptr, with wrap-around. Scanning from the far
  // end downwards lets the nearest candidate win the last assignment.
  function automatic logic [3:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                         input logic [3:0]         ptr);
    logic [3:0] sel;
    int         cand;
    sel = ptr;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (req[cand[RID_W-1:0]]) sel = 4'(cand);
    end
    return sel;
  endfunction

  // Payload byte k (1..BYTES_PER_MSG) is taken MSB byte first; the optional
  // trailer index returns the running checksum.
  function automatic logic [7:0] byte_sel(input logic [MSG_W-1:0] word,
                                          input logic [7:0]       cks,
                                          input logic [IDX_W-1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    for (int k = 1; k <= BYTES_PER_MSG; k++) begin
      if (idx == IDX_W'(k)) b = word[8*(BYTES_PER_MSG-k+1)-1 -: 8];
    end
`ifdef UART_TX_ARB_CHECKSUM_EN
    if (idx == IDX_W'(BYTES_PER_MSG + 1)) b = cks;
`else
    if (cks == 8'h00) b = b;  // checksum unused in this build
`endif
    return b;
  endfunction

  // Never start while the transmitter still finishes a byte (e.g. after a
  // reset that dropped a message mid-flight: the transmitter is not reset).
  assign start_d = (state_q == S_IDLE) && (|i_Req) && !i_Tx_Active && !i_Tx_Done;
  assign pick_d  = rr_pick(i_Req, grant_q);
  assign idx_d   = idx_q + IDX_W'(1);
  assign byte_d  = byte_sel(word_q, cks_q, idx_d);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= S_IDLE;
      ack_q   <= '0;
      dv_q    <= 1'b0;
      byte_q  <= 8'h00;
      busy_q  <= 1'b0;
      grant_q <= 4'(NUM_REQ - 1);
      idx_q   <= '0;
      cks_q   <= 8'h00;
    end else begin
      ack_q <= '0;
      dv_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_d) begin
            ack_q   <= NUM_REQ'(1) << pick_d;
            grant_q <= pick_d;
            busy_q  <= 1'b1;
            idx_q   <= '0;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          byte_q  <= 8'hA0 | {4'h0, grant_q};
          cks_q   <= 8'hA0 | {4'h0, grant_q};
          dv_q    <= 1'b1;
          state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (i_Tx_Done) state_q <= S_GAP;
        end
        S_GAP: begin
          if (!i_Tx_Done && !i_Tx_Active) begin
            if (idx_q != IDX_W'(LAST_IDX)) begin
              idx_q   <= idx_d;
              byte_q  <= byte_d;
              cks_q   <= cks_q ^ byte_d;
              dv_q    <= 1'b1;
              state_q <= S_ISSUE;
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Message word is pure data: captured at grant, no reset needed.
  always_ff @(posedge i_Clock) begin
    if (start_d) word_q <= i_Data[int'(pick_d)*MSG_W +: MSG_W];
  end

  assign o_Ack      = ack_q;
  assign o_Tx_DV    = dv_q;
  assign o_Tx_Byte  = byte_q;
  assign o_Busy     = busy_q;
  assign o_Grant_Id = grant_q;

endmodule
